// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetcher feeding a DEPTH-entry {instr, pc} FIFO for the IF stage.
// Optional ack-cycle forwarding into an empty queue is enabled by defining INST_PREFETCH_BYPASS_EN.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   target, target_next;
    logic [31:0]   redirect_tgt;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic          take, push, pop, flush, bypass_hit;

    // Ack-cycle forwarding is only possible while the queue is empty and the request is live.
    always_comb begin
`ifdef INST_PREFETCH_BYPASS_EN
        bypass_hit = (state == REQ) && mem_ack && !redirect_valid && (count == {CW{1'b0}});
`else
        bypass_hit = 1'b0;
`endif
    end

    // FIFO bookkeeping and fetch FSM next-state logic.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        target_next   = target;
        redirect_tgt  = redirect_pc & ~32'd3;
        flush         = redirect_valid;
        take          = (state == REQ) && mem_ack && !redirect_valid;
        push          = take && !(bypass_hit && deq);
        pop           = deq && (count != {CW{1'b0}}) && !redirect_valid;
        if (flush) begin
            count_next = {CW{1'b0}};
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end

        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_tgt;
                end else if (count_next < DEPTH_C) begin
                    state_next = REQ;
                end else begin
                    state_next = IDLE;
                end
            end
            REQ: begin
                if (redirect_valid && mem_ack) begin
                    fetch_pc_next = redirect_tgt;
                end else if (redirect_valid) begin
                    // Keep the stale address on the bus until the memory acks it.
                    state_next  = DISCARD;
                    target_next = redirect_tgt;
                end else if (mem_ack) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = (count_next < DEPTH_C) ? REQ : IDLE;
                end else begin
                    state_next = REQ;
                end
            end
            DISCARD: begin
                if (mem_ack && redirect_valid) begin
                    fetch_pc_next = redirect_tgt;
                    state_next    = IDLE;
                end else if (mem_ack) begin
                    fetch_pc_next = target;
                    state_next    = REQ;
                end else if (redirect_valid) begin
                    target_next = redirect_tgt;
                end else begin
                    state_next = DISCARD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers: FSM state, fetch address, redirect target, FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            target   <= RESET_PC;
            rd_ptr   <= {AW{1'b0}};
            wr_ptr   <= {AW{1'b0}};
            count    <= {CW{1'b0}};
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            target   <= target_next;
            count    <= count_next;
            if (flush) begin
                rd_ptr <= {AW{1'b0}};
                wr_ptr <= {AW{1'b0}};
            end else begin
                rd_ptr <= pop  ? rd_ptr + AW'(1) : rd_ptr;
                wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            end
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= 32'd0;
                fifo_pc[i]    <= 32'd0;
            end
        end else if (push) begin
            fifo_instr[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc;
        end
    end

    // Head presentation and memory interface.
    always_comb begin
        instr_valid  = (count != {CW{1'b0}}) || bypass_hit;
        instr_out    = bypass_hit ? mem_rdata : fifo_instr[rd_ptr];
        pc_out       = bypass_hit ? fetch_pc  : fifo_pc[rd_ptr];
        pc_plus4_out = pc_out + 32'd4;
        mem_req      = (state != IDLE);
        mem_addr     = fetch_pc;
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: directed phases plus random traffic against a queue-based model.
module tb_inst_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, deq, mem_ack;
    logic [31:0] redirect_pc, mem_rdata;
    logic        instr_valid, mem_req;
    logic [31:0] instr_out, pc_out, pc_plus4_out, mem_addr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Model: buffered words, one outstanding request (maybe marked to drop), next fetch address.
    entry_t      q[$];
    bit          pend = 1'b0;
    bit          drop = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] next_pc = RESET_PC;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq(deq), .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
        .pc_plus4_out(pc_plus4_out), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, advance the model.
    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit dq,
                        input bit ack_want, input logic [31:0] rd);
        bit          byp, exp_valid, consumed;
        entry_t      hd;
        logic [31:0] tgt;
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq            = dq;
        mem_ack        = rst ? ack_want : (ack_want && pend);
        mem_rdata      = rd;
        #1;
`ifdef INST_PREFETCH_BYPASS_EN
        byp = (q.size() == 0) && pend && !drop && mem_ack && !rv;
`else
        byp = 1'b0;
`endif
        if (!rst) begin
            exp_valid = (q.size() > 0) || byp;
            chk("mem_req", {31'd0, mem_req}, {31'd0, pend});
            chk("mem_addr", mem_addr, pend ? pend_addr : next_pc);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                hd = (q.size() > 0) ? q[0] : {rd, pend_addr};
                chk("instr_out", instr_out, hd.instr);
                chk("pc_out", pc_out, hd.pc);
                chk("pc_plus4_out", pc_plus4_out, hd.pc + 32'd4);
            end
        end
        if (rst) begin
            q.delete();
            pend    = 1'b0;
            drop    = 1'b0;
            next_pc = RESET_PC;
        end else if (rv) begin
            tgt = rpc & ~32'd3;
            q.delete();
            if (pend && mem_ack && drop) begin
                pend    = 1'b0;
                drop    = 1'b0;
                next_pc = tgt;
            end else if (pend && mem_ack) begin
                pend_addr = tgt;
                next_pc   = tgt;
            end else if (pend) begin
                drop    = 1'b1;
                next_pc = tgt;
            end else begin
                next_pc = tgt;
            end
        end else begin
            consumed = byp && dq;
            if (dq && q.size() > 0) void'(q.pop_front());
            if (pend && mem_ack && drop) begin
                drop      = 1'b0;
                pend_addr = next_pc;
            end else if (pend && mem_ack) begin
                if (!consumed) q.push_back({rd, pend_addr});
                next_pc   = pend_addr + 32'd4;
                pend_addr = next_pc;
                pend      = (q.size() < DEPTH);
            end else if (!pend && q.size() < DEPTH) begin
                pend      = 1'b1;
                pend_addr = next_pc;
            end
        end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        deq = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;

        // Reset held two cycles with a spurious ack.
        step(1, 0, 32'd0, 0, 1, 32'hBAD0_BAD0);
        step(1, 0, 32'd0, 0, 1, 32'hBAD0_BAD1);
        @(posedge clk); #1;
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);

        // Streaming with deq held high, ack every third cycle.
        for (int i = 0; i < 40; i++) step(0, 0, 32'd0, 1, (i % 3) == 2, $urandom);

        // Fill to full with deq low, then a single pop.
        for (int i = 0; i < 10; i++) step(0, 0, 32'd0, 0, 1, $urandom);
        step(0, 0, 32'd0, 1, 1, $urandom);
        for (int i = 0; i < 6; i++) step(0, 0, 32'd0, 0, 1, $urandom);

        // Redirect while a request is outstanding, late ack carries 0xDEAD.
        for (int i = 0; i < 6; i++) step(0, 0, 32'd0, 1, 0, 32'd0);
        step(0, 1, 32'h0000_0043, 0, 0, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 1, 32'h0000_DEAD);
        for (int i = 0; i < 6; i++) step(0, 0, 32'd0, 1, (i % 2) == 1, $urandom);

        // Two entries queued, then redirect + deq + ack together.
        for (int i = 0; i < 20 && !(q.size() == 2 && pend && !drop); i++)
            step(0, i == 0, 32'h0000_0200, 0, 1, $urandom);
        step(0, 1, 32'h0000_0300, 1, 1, 32'h5555_AAAA);
        for (int i = 0; i < 4; i++) step(0, 0, 32'd0, 0, 0, 32'd0);

        // Empty queue, ack 0x1234 with deq high (forwarded only when bypass is built in).
        step(0, 0, 32'd0, 1, 1, 32'h0000_1234);
        step(0, 0, 32'd0, 1, 0, 32'd0);

        // Address wrap past the top of memory.
        step(0, 1, 32'hFFFF_FFF6, 1, 0, 32'd0);
        for (int i = 0; i < 16; i++) step(0, 0, 32'd0, 1, 1, $urandom);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199, 0) == 0,
                 $urandom_range(15, 0) == 0,
                 ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom,
                 $urandom_range(1, 0) == 1,
                 $urandom_range(2, 0) == 0,
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
